// File: rtl/tile_scheduler.sv
// Frame sequencer for tile_painter: walks the screen tile by tile (wipe, gap, paint, flush).
// Latency: WIPE entered 1 cycle after frame_start; each flushed write lands 2 cycles after its BRAM address.
// Backpressure: fb_ready is sampled only in WAIT_FB; a started burst never stalls. Optional TILE_SCHED_CYCLE_COUNT_EN builds frame_cycles.
module tile_scheduler #(
  parameter int SCREEN_WIDTH  = 1280,
  parameter int SCREEN_HEIGHT = 720,
  parameter int TILE_WIDTH    = 80,
  parameter int TILE_HEIGHT   = 10,
  parameter int MAX_TRIANGLES = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             frame_start,
  input  logic [$clog2(MAX_TRIANGLES)-1:0] num_triangles_in,
  input  logic                             fb_ready,
  input  logic                             painter_done,
  input  logic [9:0]                       painter_tile_read_addr,
  output logic                             painter_active,
  output logic                             painter_wipe,
  output logic [$clog2(MAX_TRIANGLES)-1:0] painter_num_triangles,
  output logic [10:0]                      painter_x_offset,
  output logic [9:0]                       painter_y_offset,
  output logic [9:0]                       tile_bram_read_addr,
  input  logic [31:0]                      tile_bram_read_data,
  output logic                             fb_write_valid,
  output logic [19:0]                      fb_write_addr,
  output logic [31:0]                      fb_write_data,
  output logic                             busy,
  output logic                             frame_done,
  output logic [31:0]                      frame_cycles
);

  localparam int TILE_PIX = TILE_WIDTH * TILE_HEIGHT;
  localparam int COL_W    = (TILE_WIDTH  > 1) ? $clog2(TILE_WIDTH)  : 1;
  localparam int ROW_W    = (TILE_HEIGHT > 1) ? $clog2(TILE_HEIGHT) : 1;
  localparam int TRI_W    = $clog2(MAX_TRIANGLES);

  typedef enum logic [2:0] {
    S_IDLE, S_WIPE, S_GAP, S_PAINT, S_WAIT_FB, S_FLUSH, S_DRAIN, S_NEXT
  } state_t;

  state_t             state_q, state_d;
  logic [10:0]        tile_x_q, tile_x_d;
  logic [9:0]         tile_y_q, tile_y_d;
  logic [9:0]         n_q, n_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               drain_q, drain_d;
  logic [TRI_W-1:0]   num_tri_q, num_tri_d;
  logic               frame_done_q, frame_done_d;

  // Write-address pipeline, two stages deep to line up with the BRAM read latency.
  logic               v1_q, v2_q;
  logic [19:0]        a1_q, a2_q;
  logic [19:0]        pix_addr;
  logic               frame_accept;

  // A start pulse coinciding with the frame_done cycle is dropped on purpose.
  assign frame_accept = (state_q == S_IDLE) && frame_start && !frame_done_q;

  // Screen address of the pixel the flush counter is reading this cycle.
  assign pix_addr = 20'((32'(tile_y_q) + 32'(row_q)) * SCREEN_WIDTH
                        + 32'(tile_x_q) + 32'(col_q));

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tile_x_q     <= '0;
      tile_y_q     <= '0;
      n_q          <= '0;
      col_q        <= '0;
      row_q        <= '0;
      drain_q      <= 1'b0;
      num_tri_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tile_x_q     <= tile_x_d;
      tile_y_q     <= tile_y_d;
      n_q          <= n_d;
      col_q        <= col_d;
      row_q        <= row_d;
      drain_q      <= drain_d;
      num_tri_q    <= num_tri_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic: tile walk, flush counters and frame completion.
  always_comb begin
    state_d      = state_q;
    tile_x_d     = tile_x_q;
    tile_y_d     = tile_y_q;
    n_d          = n_q;
    col_d        = col_q;
    row_d        = row_q;
    drain_d      = drain_q;
    num_tri_d    = num_tri_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_accept) begin
          num_tri_d = num_triangles_in;
          tile_x_d  = '0;
          tile_y_d  = '0;
          state_d   = S_WIPE;
        end
      end
      S_WIPE: begin
        if (painter_done) state_d = S_GAP;
      end
      // One idle cycle so the painter drops back to its reset state before painting.
      S_GAP: state_d = S_PAINT;
      S_PAINT: begin
        if (painter_done) state_d = S_WAIT_FB;
      end
      S_WAIT_FB: begin
        if (fb_ready) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (n_q == 10'(TILE_PIX - 1)) begin
          n_d     = '0;
          col_d   = '0;
          row_d   = '0;
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end else begin
          n_d = n_q + 10'd1;
          if (col_q == COL_W'(TILE_WIDTH - 1)) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      // Two cycles let the last two pipelined writes leave before the offsets move.
      S_DRAIN: begin
        if (drain_q) begin
          drain_d = 1'b0;
          state_d = S_NEXT;
        end else begin
          drain_d = 1'b1;
        end
      end
      S_NEXT: begin
        state_d = S_WIPE;
        if (32'(tile_x_q) + TILE_WIDTH >= SCREEN_WIDTH) begin
          tile_x_d = '0;
          if (32'(tile_y_q) + TILE_HEIGHT >= SCREEN_HEIGHT) begin
            tile_y_d     = '0;
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            tile_y_d = tile_y_q + 10'(TILE_HEIGHT);
          end
        end else begin
          tile_x_d = tile_x_q + 11'(TILE_WIDTH);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Carry the write address and valid alongside the BRAM's two-cycle read.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      a1_q <= '0;
      a2_q <= '0;
    end else begin
      v1_q <= (state_q == S_FLUSH);
      a1_q <= (state_q == S_FLUSH) ? pix_addr : '0;
      v2_q <= v1_q;
      a2_q <= a1_q;
    end
  end

  assign painter_active        = (state_q == S_WIPE) || (state_q == S_PAINT);
  assign painter_wipe          = (state_q == S_WIPE);
  assign painter_num_triangles = num_tri_q;
  assign painter_x_offset      = tile_x_q;
  assign painter_y_offset      = tile_y_q;
  assign tile_bram_read_addr   = ((state_q == S_FLUSH) || (state_q == S_DRAIN))
                                 ? n_q : painter_tile_read_addr;
  assign fb_write_valid        = v2_q;
  assign fb_write_addr         = a2_q;
  // Data is gated so the write bus reads zero whenever no write is in flight.
  assign fb_write_data         = v2_q ? tile_bram_read_data : '0;
  assign busy                  = (state_q != S_IDLE);
  assign frame_done            = frame_done_q;

`ifdef TILE_SCHED_CYCLE_COUNT_EN
  logic [31:0] cycles_q;

  // Saturating busy-cycle counter, restarted by each accepted frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles_q <= '0;
    end else if (frame_accept) begin
      cycles_q <= '0;
    end else if ((state_q != S_IDLE) && (cycles_q != 32'hFFFF_FFFF)) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  assign frame_cycles = cycles_q;
`else
  assign frame_cycles = '0;
`endif

endmodule

// File: doc/tile_scheduler.md
# tile_scheduler

Frame-level sequencer for `tile_painter`. On a frame start it walks every 80×10 tile of the screen in raster order. For each tile it commands a wipe, then a paint pass over all triangles, then flushes the finished tile BRAM contents to the framebuffer write port. It owns the painter's `active`/`wipe`/offset inputs and arbitrates the tile BRAM read port between the painter and its own flush reader.

## Interface
Parameters:
- `SCREEN_WIDTH`, default 1280: pixels per line; must be a multiple of `TILE_WIDTH`.
- `SCREEN_HEIGHT`, default 720: lines; must be a multiple of `TILE_HEIGHT`.
- `TILE_WIDTH`, default 80: tile width in pixels, matching the painter.
- `TILE_HEIGHT`, default 10: tile height in lines, matching the painter.
- `MAX_TRIANGLES`, default 256: size of the triangle BRAM.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `frame_start` in 1: one-cycle pulse to begin a frame; honoured only in IDLE.
- `num_triangles_in` in $clog2(MAX_TRIANGLES): triangle count, latched on an accepted `frame_start`.
- `fb_ready` in 1: framebuffer can accept a full tile burst.
- `painter_done` in 1: the painter's `done`.
- `painter_tile_read_addr` in 10: the painter's `tile_bram_read_addr`.
- `painter_active`, `painter_wipe` out 1: drive the painter.
- `painter_num_triangles` out $clog2(MAX_TRIANGLES): the latched count.
- `painter_x_offset` out 11, `painter_y_offset` out 10: top-left corner of the current tile.
- `tile_bram_read_addr` out 10: muxed read address to the tile BRAM.
- `tile_bram_read_data` in 32: tile BRAM read data, 2 cycles after its address.
- `fb_write_valid` out 1, `fb_write_addr` out 20, `fb_write_data` out 32: framebuffer write stream, no backpressure.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse when the last tile has flushed.
- `frame_cycles` out 32: performance counter (see Configuration).

## Operation
- States: IDLE, WIPE, GAP, PAINT, WAIT_FB, FLUSH, DRAIN, NEXT.
- IDLE:
  - On `frame_start`, latch the triangle count and set tile_x=0, tile_y=0, then go to WIPE.
  - `frame_start` in any other state is ignored.
- WIPE:
  - `painter_active`=1, `painter_wipe`=1.
  - On `painter_done`=1, go to GAP.
- GAP:
  - `painter_active`=0 for exactly one cycle, which returns the painter to its reset state. Then go to PAINT.
- PAINT:
  - `painter_active`=1, `painter_wipe`=0.
  - On `painter_done`=1, go to WAIT_FB with `painter_active`=0.
- WAIT_FB: go to FLUSH in the cycle after `fb_ready`=1 is sampled.
- FLUSH:
  - A 10-bit counter n runs 0..TILE_WIDTH*TILE_HEIGHT-1, with `tile_bram_read_addr`=n.
  - col = n mod TILE_WIDTH and row = n / TILE_WIDTH are tracked as separate incrementing counters; no divider.
  - After the last n, go to DRAIN.
- DRAIN: 2 cycles, then NEXT.
- NEXT:
  - tile_x += TILE_WIDTH.
  - If tile_x reaches SCREEN_WIDTH: tile_x=0 and tile_y += TILE_HEIGHT.
  - If tile_y reaches SCREEN_HEIGHT: pulse `frame_done`, go to IDLE.
  - Otherwise go to WIPE.
- BRAM read-port arbitration: `tile_bram_read_addr` = the flush counter in FLUSH/DRAIN, otherwise `painter_tile_read_addr`.
- Framebuffer write:
  - `fb_write_addr` = (tile_y+row)*SCREEN_WIDTH + tile_x + col.
  - The address and a valid flag travel through a 2-stage pipeline aligned with the BRAM latency; `fb_write_data` = `tile_bram_read_data`.
- Offsets: `painter_x_offset`=tile_x and `painter_y_offset`=tile_y, held stable from WIPE through FLUSH.
- Reset:
  - Any cycle with `rst`=1 forces IDLE and clears all counters and pipelines.
  - All outputs read 0 on the next cycle, including mid-frame. `frame_cycles` is also cleared.

## Timing
- Reset value of every output is 0.
- A frame starts with WIPE entered the cycle after `frame_start`.
- Flush issues one address per cycle. The first `fb_write_valid` appears 2 cycles after the first address, with exactly TILE_WIDTH*TILE_HEIGHT consecutive valid cycles per tile.
- GAP is always exactly 1 cycle; DRAIN is always exactly 2 cycles.
- `frame_done` is high for exactly 1 cycle, in the cycle IDLE is entered.
- `busy` falls together with `frame_done`.
- If `fb_ready` drops mid-FLUSH, the burst continues. `fb_ready` is only sampled in WAIT_FB.
- A `frame_start` in the same cycle as `frame_done` is ignored.

## Configuration
- Macro: `TILE_SCHED_CYCLE_COUNT_EN`.
- Defined: `frame_cycles` is a saturating counter.
  - It is cleared on an accepted `frame_start` and increments every cycle while `busy`.
  - It holds its value in IDLE until the next frame starts.
- Undefined: no counter is built and `frame_cycles` is tied to 0.

## Test plan
- Reset then idle: all outputs are 0, and `painter_active` stays 0 for 100 cycles without `frame_start`.
- Single tile (SCREEN 80×10, model painter with `done` after 5 cycles, `fb_ready`=1):
  - Required sequence: WIPE, then one GAP cycle with `painter_active`=0, then PAINT, then 800 consecutive `fb_write_valid` with addr 0..799.
  - BRAM data must be echoed with 2-cycle alignment.
  - `frame_done` pulses once.
- Default 1280×720 with fast model painter:
  - Exactly 1152 tile bursts.
  - Offsets follow the sequence (0,0),(80,0)…(1200,0),(0,10)…(1200,710).
  - Last write address is 921599.
- Backpressure: hold `fb_ready`=0 for 50 cycles after PAINT completes → no writes and no BRAM address takeover until 1 cycle after `fb_ready` rises.
- Arbitration: during PAINT, `tile_bram_read_addr` equals `painter_tile_read_addr`. During FLUSH it equals the counter.
- Reset mid-FLUSH at n=400 → next cycle all outputs 0 and state IDLE. A new `frame_start` restarts at tile (0,0).
- With `TILE_SCHED_CYCLE_COUNT_EN`, single-tile config: `frame_cycles` equals the measured busy-cycle count. Without the macro it reads 0.
